// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: state encoding, default
// qualification length and the stability-counter width helper.
package debounce_pkg;

    // Bit 1 of the encoding is the debounced level itself, so db_level is a flop output.
    typedef enum logic [1:0] {
        S_LOW       = 2'b00,
        S_WAIT_HIGH = 2'b01,
        S_HIGH      = 2'b11,
        S_WAIT_LOW  = 2'b10
    } db_state_e;

    localparam int unsigned DEFAULT_STABLE_CYCLES = 1_000_000;

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, synchronous
// active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button into a clean level after STABLE_CYCLES stable samples.
// Define DEBOUNCER_SYNC_EN to put a 2-flop synchroniser in front of the FSM.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned CNT_W         = cnt_width(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic db_level,
    output logic db_busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic sync_level;

`ifdef DEBOUNCER_SYNC_EN
    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_in),
        .q       (sync_level)
    );
`else
    assign sync_level = btn_in;
`endif

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        db_level = 1'b0;
        db_busy  = 1'b0;

        case (state_q)
            S_LOW: begin
                if (sync_level) begin
                    state_d = S_WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            S_WAIT_HIGH: begin
                db_busy = 1'b1;
                if (!sync_level) begin
                    state_d = S_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                db_level = 1'b1;
                if (!sync_level) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOW: begin
                db_level = 1'b1;
                db_busy  = 1'b1;
                if (sync_level) begin
                    state_d = S_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with STABLE_CYCLES=4; latency
// expectations follow DEBOUNCER_SYNC_EN.
module tb_button_debouncer;

    localparam int unsigned SC = 4;
`ifdef DEBOUNCER_SYNC_EN
    localparam int unsigned SYNC_D = 2;
`else
    localparam int unsigned SYNC_D = 0;
`endif
    localparam int unsigned LAT = SC + 1 + SYNC_D;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic btn_in  = 1'b0;
    logic db_level;
    logic db_busy;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    button_debouncer #(.STABLE_CYCLES(SC)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_in   (btn_in),
        .db_level (db_level),
        .db_busy  (db_busy)
    );

    always #5 clk = ~clk;

    // Reference: level flips once SC+1 consecutive delayed samples disagree with it.
    logic        m_db  = 1'b0;
    int unsigned m_run = 0;
    logic [1:0]  m_dly = '0;

    always @(posedge clk) begin
        logic s;
        if (!reset_n) begin
            m_db  = 1'b0;
            m_run = 0;
            m_dly = '0;
        end else begin
            if (SYNC_D == 0) begin
                s = btn_in;
            end else begin
                s     = m_dly[1];
                m_dly = {m_dly[0], btn_in};
            end
            if (s == m_db) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == SC + 1) begin
                    m_db  = ~m_db;
                    m_run = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        btn_in  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_in  = 1'b1;
        repeat (3) tick();
        n_total++;
        if (db_level !== 1'b0 || db_busy !== 1'b0)
            $display("FAIL reset_state level=%b busy=%b expected 0/0", db_level, db_busy);
        else
            n_pass++;
    endtask

    task automatic test_rise_latency();
        logic exp_lvl, exp_busy;
        reset_n = 1'b1;
        for (int unsigned k = 1; k <= LAT + 2; k++) begin
            tick();
            exp_lvl  = (k >= LAT);
            exp_busy = (k >= LAT - SC) && (k < LAT);
            n_total++;
            if (db_level !== exp_lvl || db_busy !== exp_busy)
                $display("FAIL rise_latency edge %0d level=%b busy=%b expected %b/%b",
                         k, db_level, db_busy, exp_lvl, exp_busy);
            else
                n_pass++;
        end
    endtask

    task automatic test_glitch_reject();
        int unsigned busy_cnt = 0;
        do_reset();
        btn_in = 1'b1;
        for (int unsigned k = 0; k < 12; k++) begin
            if (k == 3) btn_in = 1'b0;
            tick();
            if (db_busy === 1'b1) busy_cnt++;
            n_total++;
            if (db_level !== 1'b0)
                $display("FAIL glitch_level cycle %0d level=%b expected 0", k, db_level);
            else
                n_pass++;
        end
        n_total++;
        if (busy_cnt != 3 || db_busy !== 1'b0)
            $display("FAIL glitch_busy pulse=%0d final=%b expected 3/0", busy_cnt, db_busy);
        else
            n_pass++;
    endtask

    task automatic test_bounce();
        logic [4:0] pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
        logic exp_lvl;
        do_reset();
        for (int unsigned i = 0; i < 5; i++) begin
            btn_in = pat[i];
            tick();
        end
        btn_in = 1'b1;
        for (int unsigned k = 1; k <= LAT + 1; k++) begin
            tick();
            exp_lvl = (k >= LAT);
            n_total++;
            if (db_level !== exp_lvl)
                $display("FAIL bounce edge %0d level=%b expected %b", k, db_level, exp_lvl);
            else
                n_pass++;
        end
    endtask

    task automatic test_release_glitch();
        logic exp_lvl;
        btn_in = 1'b0;
        for (int unsigned k = 1; k <= LAT; k++) begin
            tick();
            exp_lvl = (k < LAT);
            n_total++;
            if (db_level !== exp_lvl)
                $display("FAIL release edge %0d level=%b expected %b", k, db_level, exp_lvl);
            else
                n_pass++;
        end
        btn_in = 1'b1;
        repeat (LAT + 1) tick();
        n_total++;
        if (db_level !== 1'b1)
            $display("FAIL rehigh level=%b expected 1", db_level);
        else
            n_pass++;
        btn_in = 1'b0;
        tick();
        tick();
        btn_in = 1'b1;
        tick();
        btn_in = 1'b0;
        for (int unsigned k = 1; k <= LAT; k++) begin
            tick();
            exp_lvl = (k < LAT);
            n_total++;
            if (db_level !== exp_lvl)
                $display("FAIL release_glitch edge %0d level=%b expected %b", k, db_level, exp_lvl);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic exp_lvl;
        do_reset();
        btn_in = 1'b1;
        repeat (LAT - SC + 2) tick();
        n_total++;
        if (db_busy !== 1'b1 || db_level !== 1'b0)
            $display("FAIL mid_precond level=%b busy=%b expected 0/1", db_level, db_busy);
        else
            n_pass++;
        reset_n = 1'b0;
        tick();
        n_total++;
        if (db_level !== 1'b0 || db_busy !== 1'b0)
            $display("FAIL mid_reset level=%b busy=%b expected 0/0", db_level, db_busy);
        else
            n_pass++;
        reset_n = 1'b1;
        for (int unsigned k = 1; k <= LAT; k++) begin
            tick();
            exp_lvl = (k >= LAT);
            n_total++;
            if (db_level !== exp_lvl)
                $display("FAIL mid_requalify edge %0d level=%b expected %b", k, db_level, exp_lvl);
            else
                n_pass++;
        end
    endtask

    task automatic test_random();
        int unsigned hold;
        do_reset();
        for (int unsigned seg = 0; seg < 60; seg++) begin
            btn_in = 1'($urandom_range(0, 1));
            hold   = $urandom_range(1, LAT + 3);
            for (int unsigned c = 0; c < hold; c++) begin
                reset_n = ($urandom_range(0, 39) != 0);
                tick();
                n_total++;
                if (db_level !== m_db || db_busy !== (m_run != 0))
                    $display("FAIL random seg %0d level=%b busy=%b expected %b/%b",
                             seg, db_level, db_busy, m_db, (m_run != 0));
                else
                    n_pass++;
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch_reject();
        test_bounce();
        test_release_glitch();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
